// File: rtl/perr_logger.sv
// perr_logger: parity error logger for the raw-hits / miniscope RAM parity
// summary. It keeps a saturating error-clock counter and a first-error
// snapshot. It also has an 8-deep first-word-fall-through log of error bursts.
// Each log entry holds the newly failing RAMs and the bunch-crossing number.
// VME pops entries with log_rd.
//
// Handshake: the log head (log_ram/log_bxn) is valid whenever log_empty=0.
// A pop is accepted on any clock where log_rd=1 and log_empty=0. A pop on an
// empty log is ignored. A write into a full log succeeds only when an accepted
// pop occurs on the same clock.
module perr_logger #(
  parameter int MXRAM    = 37,
  parameter int CNTB     = 16,
  parameter int LOG_ADRB = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                perr_en,
  input  logic                perr_pulse,
  input  logic [MXRAM-1:0]    perr_ram_ff,
  input  logic [11:0]         bxn,
  input  logic                log_rd,
  output logic [CNTB-1:0]     perr_cnt,
  output logic                perr_cnt_sat,
  output logic                first_valid,
  output logic [MXRAM-1:0]    first_ram,
  output logic [11:0]         first_bxn,
  output logic [MXRAM-1:0]    log_ram,
  output logic [11:0]         log_bxn,
  output logic                log_empty,
  output logic                log_full,
  output logic [LOG_ADRB:0]   log_wds,
  output logic [7:0]          log_lost
);

  localparam int                DEPTH   = 1 << LOG_ADRB;
  localparam logic [LOG_ADRB:0] DEPTH_W = (LOG_ADRB+1)'(DEPTH);

  // State registers
  logic [CNTB-1:0]     r_cnt;
  logic                r_first_valid;
  logic [MXRAM-1:0]    r_first_ram;
  logic [11:0]         r_first_bxn;
  logic                r_pulse_d;
  logic [MXRAM-1:0]    r_prev_map;
  logic [LOG_ADRB-1:0] r_wr_ptr;
  logic [LOG_ADRB-1:0] r_rd_ptr;
  logic [LOG_ADRB:0]   r_wds;
  logic                r_empty;
  logic                r_full;
  logic [7:0]          r_lost;
  logic [MXRAM-1:0]    r_mem_ram [DEPTH];
  logic [11:0]         r_mem_bxn [DEPTH];

  // Combinational qualifiers
  logic                w_rst;
  logic                w_acc;
  logic                w_bst;
  logic                w_rd;
  logic                w_wr;
  logic                w_drop;
  logic                w_cnt_sat;
  logic                w_lost_sat;
  logic [MXRAM-1:0]    w_entry_ram;
  logic [LOG_ADRB:0]   w_wds_nxt;

  // Clear behaves exactly like reset and overrides every other input.
  assign w_rst       = reset | clear;
  assign w_acc       = perr_pulse & perr_en;
  // A burst starts on the first error clock after a clock without an error.
  assign w_bst       = w_acc & ~r_pulse_d;
  assign w_rd        = log_rd & ~r_empty;
  // When the log is full, a same-clock pop frees the slot the write needs.
  assign w_wr        = w_bst & (~r_full | w_rd);
  assign w_drop      = w_bst & r_full & ~w_rd;
  assign w_cnt_sat   = &r_cnt;
  assign w_lost_sat  = &r_lost;
  // Report only RAMs that were not already failing at the previous error.
  assign w_entry_ram = perr_ram_ff & ~r_prev_map;
  assign w_wds_nxt   = r_wds + (LOG_ADRB+1)'(w_wr) - (LOG_ADRB+1)'(w_rd);

  // Error counter, first-error snapshot and burst-edge tracking
  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_cnt         <= '0;
      r_first_valid <= 1'b0;
      r_first_ram   <= '0;
      r_first_bxn   <= '0;
      r_pulse_d     <= 1'b0;
      r_prev_map    <= '0;
    end else begin
      r_pulse_d <= w_acc;
      if (w_acc && !w_cnt_sat) begin
        r_cnt <= r_cnt + CNTB'(1);
      end
      if (w_acc && !r_first_valid) begin
        r_first_valid <= 1'b1;
        r_first_ram   <= perr_ram_ff;
        r_first_bxn   <= bxn;
      end
      // Track the map on every error. An all-zero map means the upstream
      // latch was reset, so RAMs that fail again must show as new.
      if (w_acc || (perr_ram_ff == '0)) begin
        r_prev_map <= perr_ram_ff;
      end
    end
  end

  // Log pointers, occupancy, registered flags and lost-burst counter
  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wds    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_lost   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + LOG_ADRB'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + LOG_ADRB'(1);
      end
      r_wds   <= w_wds_nxt;
      r_empty <= (w_wds_nxt == '0);
      r_full  <= (w_wds_nxt == DEPTH_W);
      if (w_drop && !w_lost_sat) begin
        r_lost <= r_lost + 8'd1;
      end
    end
  end

  // Log storage; writes land at the tail and need no reset
  always_ff @(posedge clock) begin
    if (!w_rst && w_wr) begin
      r_mem_ram[r_wr_ptr] <= w_entry_ram;
      r_mem_bxn[r_wr_ptr] <= bxn;
    end
  end

  assign perr_cnt     = r_cnt;
  assign perr_cnt_sat = w_cnt_sat;
  assign first_valid  = r_first_valid;
  assign first_ram    = r_first_ram;
  assign first_bxn    = r_first_bxn;
  assign log_empty    = r_empty;
  assign log_full     = r_full;
  assign log_wds      = r_wds;
  assign log_lost     = r_lost;
  // The head entry falls through; an empty log shows zeros
  assign log_ram      = r_empty ? '0 : r_mem_ram[r_rd_ptr];
  assign log_bxn      = r_empty ? '0 : r_mem_bxn[r_rd_ptr];

endmodule

// File: tb/tb_perr_logger.sv
// Testbench for perr_logger: directed scenarios plus a randomized run,
// checked against a queue-based behavioural model of the logger.
module tb_perr_logger;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        perr_en = 1'b0;
  logic        perr_pulse = 1'b0;
  logic [36:0] perr_ram_ff = '0;
  logic [11:0] bxn = '0;
  logic        log_rd = 1'b0;

  logic [15:0] perr_cnt;
  logic        perr_cnt_sat, first_valid, log_empty, log_full;
  logic [36:0] first_ram, log_ram;
  logic [11:0] first_bxn, log_bxn;
  logic [3:0]  log_wds;
  logic [7:0]  log_lost;

  // Narrow-counter instance so counter saturation is reachable quickly
  logic [3:0]  s_perr_cnt;
  logic        s_perr_cnt_sat, s_first_valid, s_log_empty, s_log_full;
  logic [36:0] s_first_ram, s_log_ram;
  logic [11:0] s_first_bxn, s_log_bxn;
  logic [3:0]  s_log_wds;
  logic [7:0]  s_log_lost;

  always #5 clock = ~clock;

  perr_logger dut (
    .clock(clock), .reset(reset), .clear(clear), .perr_en(perr_en),
    .perr_pulse(perr_pulse), .perr_ram_ff(perr_ram_ff), .bxn(bxn), .log_rd(log_rd),
    .perr_cnt(perr_cnt), .perr_cnt_sat(perr_cnt_sat), .first_valid(first_valid),
    .first_ram(first_ram), .first_bxn(first_bxn), .log_ram(log_ram), .log_bxn(log_bxn),
    .log_empty(log_empty), .log_full(log_full), .log_wds(log_wds), .log_lost(log_lost)
  );

  perr_logger #(.CNTB(4)) dut_s (
    .clock(clock), .reset(reset), .clear(clear), .perr_en(perr_en),
    .perr_pulse(perr_pulse), .perr_ram_ff(perr_ram_ff), .bxn(bxn), .log_rd(log_rd),
    .perr_cnt(s_perr_cnt), .perr_cnt_sat(s_perr_cnt_sat), .first_valid(s_first_valid),
    .first_ram(s_first_ram), .first_bxn(s_first_bxn), .log_ram(s_log_ram), .log_bxn(s_log_bxn),
    .log_empty(s_log_empty), .log_full(s_log_full), .log_wds(s_log_wds), .log_lost(s_log_lost)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Log entries as {ram, bxn}; front of the queue is the head.
  logic [48:0] exp_q[$];
  int          m_n;        // accepted error clocks since reset
  logic        m_fv;
  logic [36:0] m_fram;
  logic [11:0] m_fbxn;
  int          m_lost;
  logic [36:0] m_prev;
  logic        m_pacc;

  function automatic logic [15:0] e_cnt();
    return (m_n > 65535) ? 16'hFFFF : 16'(m_n);
  endfunction
  function automatic logic [3:0] e_scnt();
    return (m_n > 15) ? 4'hF : 4'(m_n);
  endfunction
  function automatic logic [36:0] e_head_ram();
    return (exp_q.size() > 0) ? exp_q[0][48:12] : 37'h0;
  endfunction
  function automatic logic [11:0] e_head_bxn();
    return (exp_q.size() > 0) ? exp_q[0][11:0] : 12'h0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_n = 0; m_fv = 1'b0; m_fram = '0; m_fbxn = '0;
    m_lost = 0; m_prev = '0; m_pacc = 1'b0;
  endtask

  task automatic model_step(input logic rst, input logic clr, input logic en,
                            input logic pulse, input logic [36:0] ram,
                            input logic [11:0] b, input logic rd);
    logic acc, bst, pop;
    int sz;
    if (rst || clr) begin
      model_clear();
    end else begin
      acc = en & pulse;
      bst = acc & ~m_pacc;
      sz  = exp_q.size();
      pop = rd && (sz > 0);
      if (pop) void'(exp_q.pop_front());
      if (bst) begin
        if (sz < 8 || pop) exp_q.push_back({ram & ~m_prev, b});
        else if (m_lost < 255) m_lost++;
      end
      if (acc) begin
        m_n++;
        if (!m_fv) begin m_fv = 1'b1; m_fram = ram; m_fbxn = b; end
      end
      if (acc) m_prev = ram;
      else if (ram == 37'h0) m_prev = '0;
      m_pacc = acc;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive inputs, let the edge happen, update the model, sample #1 later.
  task automatic cyc(input logic rst, input logic clr, input logic en, input logic pulse,
                     input logic [36:0] ram, input logic [11:0] b, input logic rd);
    reset = rst; clear = clr; perr_en = en; perr_pulse = pulse;
    perr_ram_ff = ram; bxn = b; log_rd = rd;
    @(posedge clock);
    model_step(rst, clr, en, pulse, ram, b, rd);
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, '0, '0, 0);
    cyc(1, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic idle(input logic [36:0] ram);
    cyc(0, 0, 1, 0, ram, 12'($urandom), 0);
  endtask

  task automatic err(input logic [36:0] ram, input logic [11:0] b);
    cyc(0, 0, 1, 1, ram, b, 0);
  endtask

  task automatic pop();
    cyc(0, 0, 1, 0, perr_ram_ff, 12'($urandom), 1);
  endtask

  function automatic logic [36:0] rnd_map();
    return {5'($urandom), 32'($urandom)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if ({perr_cnt, perr_cnt_sat, first_valid} !== 18'h0) begin
      n_errors++; $display("FAIL reset_cnt: got %h expected 0", {perr_cnt, perr_cnt_sat, first_valid}); end
    n_checks++; if ({first_ram, first_bxn} !== 49'h0) begin
      n_errors++; $display("FAIL reset_first: got %h expected 0", {first_ram, first_bxn}); end
    n_checks++; if ({log_ram, log_bxn} !== 49'h0) begin
      n_errors++; $display("FAIL reset_head: got %h expected 0", {log_ram, log_bxn}); end
    n_checks++; if ({log_empty, log_full, log_wds, log_lost} !== 14'h2000) begin
      n_errors++; $display("FAIL reset_log: got %h expected 2000", {log_empty, log_full, log_wds, log_lost}); end
    n_checks++; if (s_perr_cnt !== 4'h0) begin
      n_errors++; $display("FAIL reset_scnt: got %h expected 0", s_perr_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    err(37'h1, 12'h123);
    idle(37'h1);
    n_checks++; if (perr_cnt !== 16'd1) begin
      n_errors++; $display("FAIL single_cnt: got %0d expected 1", perr_cnt); end
    n_checks++; if ({first_valid, first_ram, first_bxn} !== {1'b1, 37'h1, 12'h123}) begin
      n_errors++; $display("FAIL single_first: got %b %h %h expected 1 1 123", first_valid, first_ram, first_bxn); end
    n_checks++; if ({log_wds, log_ram, log_bxn} !== {4'd1, 37'h1, 12'h123}) begin
      n_errors++; $display("FAIL single_log: got %0d %h %h expected 1 1 123", log_wds, log_ram, log_bxn); end
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 5; i++) err(37'h1, 12'h010 + 12'(i));
    idle(37'h1);
    err(37'h3, 12'h200);
    idle(37'h3);
    n_checks++; if (perr_cnt !== 16'd6) begin
      n_errors++; $display("FAIL burst_cnt: got %0d expected 6", perr_cnt); end
    n_checks++; if (log_wds !== 4'd2) begin
      n_errors++; $display("FAIL burst_wds: got %0d expected 2", log_wds); end
    n_checks++; if ({first_ram, first_bxn} !== {37'h1, 12'h010}) begin
      n_errors++; $display("FAIL burst_first: got %h %h expected 1 010", first_ram, first_bxn); end
    n_checks++; if ({log_ram, log_bxn} !== {37'h1, 12'h010}) begin
      n_errors++; $display("FAIL burst_head1: got %h %h expected 1 010", log_ram, log_bxn); end
    pop();
    n_checks++; if ({log_ram, log_bxn, log_wds} !== {37'h2, 12'h200, 4'd1}) begin
      n_errors++; $display("FAIL burst_head2: got %h %h %0d expected 2 200 1", log_ram, log_bxn, log_wds); end
  endtask

  task automatic test_overflow();
    logic [11:0] bx[10];
    logic [36:0] mp;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mp = rnd_map();
      bx[i] = 12'h400 + 12'(i * 17);
      err(mp, bx[i]);
      idle(mp);
    end
    n_checks++; if ({log_full, log_empty, log_wds, log_lost} !== {1'b1, 1'b0, 4'd8, 8'd2}) begin
      n_errors++; $display("FAIL ovf_flags: got full=%b empty=%b wds=%0d lost=%0d expected 1 0 8 2",
                           log_full, log_empty, log_wds, log_lost); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if ({log_ram, log_bxn} !== {e_head_ram(), bx[i]}) begin
        n_errors++; $display("FAIL ovf_entry%0d: got %h %h expected %h %h", i, log_ram, log_bxn, e_head_ram(), bx[i]); end
      pop();
    end
    n_checks++; if ({log_empty, log_full, log_wds, log_ram, log_bxn} !== {1'b1, 1'b0, 4'd0, 49'h0}) begin
      n_errors++; $display("FAIL ovf_drained: got empty=%b wds=%0d head=%h expected 1 0 0", log_empty, log_wds, log_ram); end
    pop();
    n_checks++; if ({log_empty, log_wds, log_lost} !== {1'b1, 4'd0, 8'd2}) begin
      n_errors++; $display("FAIL underflow: got empty=%b wds=%0d lost=%0d expected 1 0 2", log_empty, log_wds, log_lost); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      err(37'h1 << i, 12'h300 + 12'(i));
      idle(37'h1 << i);
    end
    n_checks++; if (log_full !== 1'b1) begin
      n_errors++; $display("FAIL fp_full: got %b expected 1", log_full); end
    cyc(0, 0, 1, 1, 37'h1F_0000_0000, 12'h3AA, 1);
    n_checks++; if ({log_wds, log_lost, log_full, log_bxn} !== {4'd8, 8'd0, 1'b1, 12'h301}) begin
      n_errors++; $display("FAIL fp_same_clock: got wds=%0d lost=%0d full=%b head=%h expected 8 0 1 301",
                           log_wds, log_lost, log_full, log_bxn); end
    idle(37'h1F_0000_0000);
    for (int i = 0; i < 7; i++) pop();
    n_checks++; if ({log_ram, log_bxn, log_wds} !== {37'h1F_0000_0000, 12'h3AA, 4'd1}) begin
      n_errors++; $display("FAIL fp_tail: got %h %h %0d expected 1f00000000 3aa 1", log_ram, log_bxn, log_wds); end
  endtask

  task automatic test_map_collapse();
    do_reset();
    err(37'h5, 12'h001); idle(37'h5);
    err(37'h7, 12'h002); idle(37'h0);
    err(37'h5, 12'h003); idle(37'h5);
    n_checks++; if (log_ram !== 37'h5) begin
      n_errors++; $display("FAIL mc_e1: got %h expected 5", log_ram); end
    pop();
    n_checks++; if (log_ram !== 37'h2) begin
      n_errors++; $display("FAIL mc_e2: got %h expected 2", log_ram); end
    pop();
    n_checks++; if (log_ram !== 37'h5) begin
      n_errors++; $display("FAIL mc_e3: got %h expected 5", log_ram); end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    for (int i = 0; i < 14; i++) err(37'h8, 12'h050);
    n_checks++; if ({s_perr_cnt, s_perr_cnt_sat} !== {4'hE, 1'b0}) begin
      n_errors++; $display("FAIL sat_pre: got %h %b expected e 0", s_perr_cnt, s_perr_cnt_sat); end
    for (int i = 0; i < 3; i++) err(37'h8, 12'h050);
    n_checks++; if ({s_perr_cnt, s_perr_cnt_sat} !== {4'hF, 1'b1}) begin
      n_errors++; $display("FAIL sat_hold: got %h %b expected f 1", s_perr_cnt, s_perr_cnt_sat); end
    n_checks++; if ({perr_cnt, perr_cnt_sat} !== {16'd17, 1'b0}) begin
      n_errors++; $display("FAIL sat_wide: got %0d %b expected 17 0", perr_cnt, perr_cnt_sat); end
    cyc(0, 1, 1, 1, 37'h8, 12'h051, 0);
    n_checks++; if ({perr_cnt, s_perr_cnt, perr_cnt_sat, s_perr_cnt_sat, first_valid} !== 25'h0) begin
      n_errors++; $display("FAIL clr_cnt: got %h %h expected 0 0", perr_cnt, s_perr_cnt); end
    n_checks++; if ({log_empty, log_wds, log_lost, log_ram, first_ram} !== {1'b1, 12'h0, 74'h0}) begin
      n_errors++; $display("FAIL clr_log: got empty=%b wds=%0d lost=%0d expected 1 0 0", log_empty, log_wds, log_lost); end
  endtask

  task automatic test_disabled();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 37'hFF, 12'h060, 0);
    n_checks++; if ({perr_cnt, first_valid, log_empty, log_wds} !== {16'h0, 1'b0, 1'b1, 4'd0}) begin
      n_errors++; $display("FAIL disabled: got cnt=%0d fv=%b empty=%b wds=%0d expected 0 0 1 0",
                           perr_cnt, first_valid, log_empty, log_wds); end
  endtask

  task automatic test_lost_sat();
    do_reset();
    for (int i = 0; i < 270; i++) begin
      err(rnd_map(), 12'($urandom));
      idle(37'h0);
    end
    n_checks++; if ({log_lost, log_wds} !== {8'd255, 4'd8}) begin
      n_errors++; $display("FAIL lost_sat: got lost=%0d wds=%0d expected 255 8", log_lost, log_wds); end
  endtask

  task automatic test_random();
    logic [36:0] mp;
    logic en, pl, rd, cl;
    do_reset();
    mp = rnd_map();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) mp = ($urandom_range(0, 3) == 0) ? 37'h0 : rnd_map();
      else if ($urandom_range(0, 3) == 0) mp = mp | (37'h1 << $urandom_range(0, 36));
      en = ($urandom_range(0, 7) != 0);
      pl = ($urandom_range(0, 2) != 0);
      rd = (i % 400 < 200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      cl = ($urandom_range(0, 499) == 0);
      cyc(0, cl, en, pl, mp, 12'($urandom), rd);
      n_checks++; if ({perr_cnt, perr_cnt_sat} !== {e_cnt(), e_cnt() == 16'hFFFF}) begin
        n_errors++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", i, perr_cnt, e_cnt()); end
      n_checks++; if (s_perr_cnt !== e_scnt()) begin
        n_errors++; $display("FAIL rnd_scnt@%0d: got %0d expected %0d", i, s_perr_cnt, e_scnt()); end
      n_checks++; if ({first_valid, first_ram, first_bxn} !== {m_fv, m_fram, m_fbxn}) begin
        n_errors++; $display("FAIL rnd_first@%0d: got %b %h %h expected %b %h %h", i,
                             first_valid, first_ram, first_bxn, m_fv, m_fram, m_fbxn); end
      n_checks++; if ({log_wds, log_empty, log_full, log_lost} !==
                      {4'(exp_q.size()), exp_q.size() == 0, exp_q.size() == 8, 8'(m_lost)}) begin
        n_errors++; $display("FAIL rnd_flags@%0d: got wds=%0d e=%b f=%b lost=%0d expected %0d %0d", i,
                             log_wds, log_empty, log_full, log_lost, exp_q.size(), m_lost); end
      n_checks++; if ({log_ram, log_bxn} !== {e_head_ram(), e_head_bxn()}) begin
        n_errors++; $display("FAIL rnd_head@%0d: got %h %h expected %h %h", i,
                             log_ram, log_bxn, e_head_ram(), e_head_bxn()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_map_collapse();
    test_saturate_clear();
    test_disabled();
    test_lost_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
